posit_record_gearbox: RTL and testbench

- Parametrised posit-record transmit gearbox. Accepts one deconstructed posit record per handshake: value, sum or product kind, generic NBITS/ES.
- Packs the record into a fixed bit layout and streams it as BUS_W-bit beats over a valid/ready link, LSB beat first.
- Optional compression sends zero/inf records as a single beat.
- Sits between posit arithmetic pipelines and narrow inter-FPGA/host links.

---
 rtl/posit_record_gearbox_pkg.sv | 47 ++++
 rtl/posit_record_gearbox_if.sv | 23 ++
 rtl/posit_record_gearbox_shifter.sv | 35 +++
 rtl/posit_record_gearbox.sv | 94 +++++++++
 tb/tb_posit_record_gearbox.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/posit_record_gearbox_pkg.sv
// Shared definitions for the posit-record gearbox: record geometry, kinds, field layout.
package posit_record_gearbox_pkg;

  typedef enum logic [1:0] {
    KIND_VALUE   = 2'd0,
    KIND_SUM     = 2'd1,
    KIND_PRODUCT = 2'd2
  } kind_e;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_e;

  // Record layout from bit 0 upward: zero, inf, fraction, scale, sgn.
  localparam int unsigned ZERO_POS = 0;
  localparam int unsigned INF_POS  = 1;
  localparam int unsigned FRAC_LSB = 2;

  function automatic int unsigned scale_w_of(int unsigned scale_w, int unsigned kind);
    return (kind == int'(KIND_PRODUCT)) ? scale_w + 1 : scale_w;
  endfunction

  function automatic int unsigned fw_of(int unsigned nbits, int unsigned es, int unsigned kind);
    if (kind == int'(KIND_SUM))     return nbits + 1 - es;
    if (kind == int'(KIND_PRODUCT)) return 2 * (nbits - 2 - es);
    return nbits - 3 - es;
  endfunction

  function automatic int unsigned rec_w_of(int unsigned nbits, int unsigned es,
                                           int unsigned scale_w, int unsigned kind);
    return 1 + scale_w_of(scale_w, kind) + fw_of(nbits, es, kind) + 2;
  endfunction

  function automatic int unsigned beats_of(int unsigned rec_w, int unsigned bus_w);
    return (rec_w + bus_w - 1) / bus_w;
  endfunction

  function automatic logic is_special(logic inf, logic zero);
    return inf | zero;
  endfunction

  function automatic logic is_bad(logic inf, logic zero);
    return inf & zero;
  endfunction

endpackage

// File: rtl/posit_record_gearbox_if.sv
// Record-in / beat-out stream bundle; master is the gearbox side, slave the environment.
interface posit_record_gearbox_if #(
  parameter int unsigned REC_W = 38,
  parameter int unsigned BUS_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [REC_W-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [BUS_W-1:0] out_data;
  logic             out_last;

  modport master (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport slave (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/posit_record_gearbox_shifter.sv
// BUS_W-step record shift register with beat counter; load wins over shift.
module posit_record_gearbox_shifter #(
  parameter int unsigned REC_W = 38,
  parameter int unsigned BUS_W = 16,
  parameter int unsigned BEATS = 3,
  parameter int unsigned CW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [REC_W-1:0] ld_data,
  input  logic             shift,
  output logic [BUS_W-1:0] beat,
  output logic [CW-1:0]    beat_cnt
);
  localparam int unsigned SH_W = BEATS * BUS_W;

  logic [SH_W-1:0] sh;

  // Zero-extension to a whole number of beats keeps padding bits of the final beat at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh       <= '0;
      beat_cnt <= '0;
    end else if (load) begin
      sh       <= SH_W'(ld_data);
      beat_cnt <= '0;
    end else if (shift) begin
      sh       <= sh >> BUS_W;
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  assign beat = sh[BUS_W-1:0];
endmodule

// File: rtl/posit_record_gearbox.sv
// Posit-record transmit gearbox: latches one packed record, streams it LSB beat first.
module posit_record_gearbox
  import posit_record_gearbox_pkg::*;
#(
  parameter int unsigned NBITS    = 32,
  parameter int unsigned ES       = 3,
  parameter int unsigned SCALE_W  = 9,
  parameter int unsigned KIND     = 0,
  parameter int unsigned BUS_W    = 16,
  parameter int unsigned COMPRESS = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  posit_record_gearbox_if.master bus,
  output logic [31:0]            rec_count,
  output logic                   err_flags
);
  localparam int unsigned REC_W = rec_w_of(NBITS, ES, SCALE_W, KIND);
  localparam int unsigned BEATS = beats_of(REC_W, BUS_W);
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_e           state;
  logic             out_valid_q;
  logic             out_last_q;
  logic [CW-1:0]    beat_cnt;
  logic [CW-1:0]    nxt_cnt;
  logic [BUS_W-1:0] beat;
  logic             accept;
  logic             advance;
  logic             done;

  always_comb begin
    done    = (state == ST_SEND) & bus.out_ready & out_last_q;
    advance = (state == ST_SEND) & bus.out_ready & ~out_last_q;
    accept  = bus.in_valid & bus.in_ready;
    nxt_cnt = beat_cnt + 1'b1;
  end

  assign bus.in_ready  = (state == ST_IDLE) | done;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = beat;

  posit_record_gearbox_shifter #(
    .REC_W (REC_W),
    .BUS_W (BUS_W),
    .BEATS (BEATS),
    .CW    (CW)
  ) u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .ld_data  (bus.in_data),
    .shift    (advance),
    .beat     (beat),
    .beat_cnt (beat_cnt)
  );

  // out_last is precomputed at load/shift so it is valid in the same cycle as its beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      rec_count   <= '0;
      err_flags   <= 1'b0;
    end else begin
      if (accept) begin
        out_last_q <= ((COMPRESS != 0) && is_special(bus.in_data[INF_POS], bus.in_data[ZERO_POS]))
                      || (BEATS == 1);
        if (is_bad(bus.in_data[INF_POS], bus.in_data[ZERO_POS])) err_flags <= 1'b1;
      end else if (advance) begin
        out_last_q <= (nxt_cnt == CW'(BEATS - 1));
      end
      if (done) rec_count <= rec_count + 32'd1;
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            state       <= ST_SEND;
            out_valid_q <= 1'b1;
          end
        end
        ST_SEND: begin
          if (done && !bus.in_valid) begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_posit_record_gearbox.sv
// Directed bench for posit_record_gearbox: default-parameter DUT plus a COMPRESS=0 twin.
module tb_posit_record_gearbox;
  logic        clk;
  logic        rst_n;
  logic [31:0] rc_b, rc_n;
  logic        err_b, err_n;
  int          tests;
  int          fails;

  localparam logic [37:0] REC_A = 38'h20_5555_5554;
  localparam logic [37:0] REC_B = 38'h1F_0F0F_A5A4;

  posit_record_gearbox_if #(.REC_W(38), .BUS_W(16)) b();
  posit_record_gearbox_if #(.REC_W(38), .BUS_W(16)) n();

  posit_record_gearbox u_dut (
    .clk(clk), .rst_n(rst_n), .bus(b), .rec_count(rc_b), .err_flags(err_b)
  );

  posit_record_gearbox #(.COMPRESS(0)) u_nc (
    .clk(clk), .rst_n(rst_n), .bus(n), .rec_count(rc_n), .err_flags(err_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [15:0] data, input logic last);
    chk({tag, "_valid"}, 64'(b.out_valid), 64'd1);
    chk({tag, "_data"},  64'(b.out_data),  64'(data));
    chk({tag, "_last"},  64'(b.out_last),  64'(last));
  endtask

  task automatic chk_nbeat(input string tag, input logic [15:0] data, input logic last);
    chk({tag, "_valid"}, 64'(n.out_valid), 64'd1);
    chk({tag, "_data"},  64'(n.out_data),  64'(data));
    chk({tag, "_last"},  64'(n.out_last),  64'(last));
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    b.in_valid = 1'b0; b.in_data = '0; b.out_ready = 1'b1;
    n.in_valid = 1'b0; n.in_data = '0; n.out_ready = 1'b1;

    // reset state
    @(negedge clk);
    chk("rst_valid", 64'(b.out_valid), 64'd0);
    chk("rst_last",  64'(b.out_last),  64'd0);
    chk("rst_data",  64'(b.out_data),  64'd0);
    chk("rst_count", 64'(rc_b),        64'd0);
    chk("rst_err",   64'(err_b),       64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 64'(b.in_ready), 64'd1);

    // single full record, first beat one cycle after accept
    b.in_valid = 1'b1; b.in_data = REC_A;
    @(negedge clk);
    b.in_valid = 1'b0;
    chk_beat("a_b0", 16'h5554, 1'b0);
    chk("a_b0_ready", 64'(b.in_ready), 64'd0);
    @(negedge clk);
    chk_beat("a_b1", 16'h5555, 1'b0);
    @(negedge clk);
    chk_beat("a_b2", 16'h0020, 1'b1);
    chk("a_b2_ready", 64'(b.in_ready), 64'd1);
    @(negedge clk);
    chk("a_idle", 64'(b.out_valid), 64'd0);
    chk("a_count", 64'(rc_b), 64'd1);

    // compressed zero record
    b.in_valid = 1'b1; b.in_data = 38'h1;
    @(negedge clk);
    b.in_valid = 1'b0;
    chk_beat("z_b0", 16'h0001, 1'b1);
    @(negedge clk);
    chk("z_idle", 64'(b.out_valid), 64'd0);
    chk("z_count", 64'(rc_b), 64'd2);

    // back-to-back records with in_valid held high
    b.in_valid = 1'b1; b.in_data = REC_A;
    @(negedge clk);
    b.in_data = REC_B;
    chk_beat("bb_a0", 16'h5554, 1'b0);
    @(negedge clk);
    chk_beat("bb_a1", 16'h5555, 1'b0);
    @(negedge clk);
    chk_beat("bb_a2", 16'h0020, 1'b1);
    chk("bb_ready", 64'(b.in_ready), 64'd1);
    @(negedge clk);
    b.in_valid = 1'b0;
    chk_beat("bb_b0", 16'hA5A4, 1'b0);
    @(negedge clk);
    chk_beat("bb_b1", 16'h0F0F, 1'b0);
    @(negedge clk);
    chk_beat("bb_b2", 16'h001F, 1'b1);
    @(negedge clk);
    chk("bb_idle", 64'(b.out_valid), 64'd0);
    chk("bb_count", 64'(rc_b), 64'd4);

    // back-pressure: out_ready 1,0,0,1
    b.in_valid = 1'b1; b.in_data = REC_A;
    @(negedge clk);
    b.in_valid = 1'b0;
    chk_beat("bp_b0", 16'h5554, 1'b0);
    @(negedge clk);
    chk_beat("bp_b1", 16'h5555, 1'b0);
    b.out_ready = 1'b0;
    @(negedge clk);
    chk_beat("bp_stall1", 16'h5555, 1'b0);
    @(negedge clk);
    chk_beat("bp_stall2", 16'h5555, 1'b0);
    chk("bp_ready", 64'(b.in_ready), 64'd0);
    b.out_ready = 1'b1;
    @(negedge clk);
    chk_beat("bp_b2", 16'h0020, 1'b1);
    @(negedge clk);
    chk("bp_count", 64'(rc_b), 64'd5);

    // inf=zero=1: error flag, still one compressed beat
    b.in_valid = 1'b1; b.in_data = 38'h3;
    @(negedge clk);
    b.in_valid = 1'b0;
    chk_beat("e_b0", 16'h0003, 1'b1);
    chk("e_err", 64'(err_b), 64'd1);
    @(negedge clk);
    chk("e_count", 64'(rc_b), 64'd6);

    // uncompressed zero record on the COMPRESS=0 twin
    n.in_valid = 1'b1; n.in_data = 38'h1;
    @(negedge clk);
    n.in_valid = 1'b0;
    chk_nbeat("nc_b0", 16'h0001, 1'b0);
    @(negedge clk);
    chk_nbeat("nc_b1", 16'h0000, 1'b0);
    @(negedge clk);
    chk_nbeat("nc_b2", 16'h0000, 1'b1);
    @(negedge clk);
    chk("nc_idle", 64'(n.out_valid), 64'd0);
    chk("nc_count", 64'(rc_n), 64'd1);
    chk("nc_err", 64'(err_n), 64'd0);
    chk("e_sticky", 64'(err_b), 64'd1);

    // reset mid-record, then restart from beat 0
    b.in_valid = 1'b1; b.in_data = REC_A;
    @(negedge clk);
    b.in_valid = 1'b0;
    chk_beat("r_b0", 16'h5554, 1'b0);
    @(negedge clk);
    chk_beat("r_b1", 16'h5555, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("r_async_valid", 64'(b.out_valid), 64'd0);
    chk("r_count", 64'(rc_b), 64'd0);
    chk("r_err", 64'(err_b), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    b.in_valid = 1'b1; b.in_data = REC_A;
    @(negedge clk);
    b.in_valid = 1'b0;
    chk_beat("r2_b0", 16'h5554, 1'b0);
    @(negedge clk);
    chk_beat("r2_b1", 16'h5555, 1'b0);
    @(negedge clk);
    chk_beat("r2_b2", 16'h0020, 1'b1);
    @(negedge clk);
    chk("r2_count", 64'(rc_b), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
